// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - pipeline-to-MDU handshake and HI/LO bus
//
// Ports (signals carried by the interface):
//   start, funct, rs_val, rt_val, abort : pipeline -> MDU issue and flush
//   busy, done, stall, illegal          : MDU -> pipeline status
//   hi, lo, mf_data                     : architectural HI/LO and mfhi/mflo read data
// Modports: master (pipeline side), slave (MDU side).
interface mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             abort;
    logic             busy;
    logic             done;
    logic             stall;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output start, funct, rs_val, rt_val, abort,
        input  busy, done, stall, illegal, hi, lo, mf_data
    );

    modport slave (
        input  start, funct, rs_val, rt_val, abort,
        output busy, done, stall, illegal, hi, lo, mf_data
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multiply/divide unit owning HI/LO
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : mdu_ctrl_if.slave (start/funct/rs_val/rt_val/abort in;
//            busy/done/stall/illegal/hi/lo/mf_data out)
// Optional feature macro: MDU_DIV_EN (when defined, div/divu are supported;
// otherwise they are reported as illegal and the divider is not built).
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mdu_ctrl_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ITER,
        S_FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic             is_signed;
    logic             neg_q;
    // p_hi/p_lo: product accumulator for multiply, remainder/quotient for divide
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    // multiplicand for multiply, divisor magnitude for divide
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             illegal_q;
`ifdef MDU_DIV_EN
    logic             is_div;
    logic             neg_r;
`endif

    // Decode
    logic is_mul_op;
    logic is_div_op;
    logic is_mf;
    logic is_mt;
    logic known;
    logic seq_op;
    logic supported;

    always_comb begin
        is_mul_op = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
        is_div_op = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
        is_mf     = (bus.funct == F_MFHI) || (bus.funct == F_MFLO);
        is_mt     = (bus.funct == F_MTHI) || (bus.funct == F_MTLO);
        known     = is_mul_op | is_div_op | is_mf | is_mt;
`ifdef MDU_DIV_EN
        seq_op    = is_mul_op | is_div_op;
`else
        seq_op    = is_mul_op;
`endif
        supported = seq_op | is_mf | is_mt;
    end

    // Datapath helpers
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        // Magnitude of MIN stays MIN, which is the correct unsigned magnitude.
        a_abs    = (is_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
        b_abs    = (is_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;
        mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
        prod_neg = -{p_hi, p_lo};
    end

`ifdef MDU_DIV_EN
    // Restoring step: shift the next dividend bit into the partial remainder
    // and try to subtract the divisor; bit WIDTH set means it did not fit.
    logic [WIDTH:0] div_trial;

    always_comb begin
        div_trial = {p_hi, p_lo[WIDTH-1]} - {1'b0, mcand};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_raw     <= '0;
            b_raw     <= '0;
            is_signed <= 1'b0;
            neg_q     <= 1'b0;
            p_hi      <= '0;
            p_lo      <= '0;
            mcand     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef MDU_DIV_EN
            is_div    <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (bus.abort && state != S_IDLE) begin
                // HI/LO are only written in FIX, so dropping out here leaves
                // the pre-operation values intact.
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // busy is low in IDLE, so start alone is the accept condition
                        if (bus.start) begin
                            if (seq_op) begin
                                state     <= S_SETUP;
                                busy_q    <= 1'b1;
                                a_raw     <= bus.rs_val;
                                b_raw     <= bus.rt_val;
                                is_signed <= (bus.funct == F_MULT) || (bus.funct == F_DIV);
`ifdef MDU_DIV_EN
                                is_div    <= is_div_op;
`endif
                            end else if (is_mt) begin
                                if (bus.funct == F_MTHI) begin
                                    hi_q <= bus.rs_val;
                                end else begin
                                    lo_q <= bus.rs_val;
                                end
                            end else if (!supported) begin
                                illegal_q <= 1'b1;
                            end
                        end
                    end
                    S_SETUP: begin
                        cnt   <= '0;
                        p_hi  <= '0;
                        neg_q <= is_signed & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                        state <= S_ITER;
`ifdef MDU_DIV_EN
                        neg_r <= is_signed & a_raw[WIDTH-1];
                        if (is_div) begin
                            p_lo  <= a_abs;
                            mcand <= b_abs;
                        end else begin
                            p_lo  <= b_abs;
                            mcand <= a_abs;
                        end
`else
                        p_lo  <= b_abs;
                        mcand <= a_abs;
`endif
                    end
                    S_ITER: begin
`ifdef MDU_DIV_EN
                        if (is_div) begin
                            if (!div_trial[WIDTH]) begin
                                p_hi <= div_trial[WIDTH-1:0];
                                p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
                                p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
                        end
`else
                        {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
`endif
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
`ifdef MDU_DIV_EN
                        if (is_div) begin
                            if (mcand == '0) begin
                                lo_q <= '1;
                                hi_q <= a_raw;
                            end else begin
                                lo_q <= neg_q ? -p_lo : p_lo;
                                hi_q <= neg_r ? -p_hi : p_hi;
                            end
                        end else begin
                            {hi_q, lo_q} <= neg_q ? prod_neg : {p_hi, p_lo};
                        end
`else
                        {hi_q, lo_q} <= neg_q ? prod_neg : {p_hi, p_lo};
`endif
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    // Stall covers every HI/LO-group code, even ones this build rejects.
    assign bus.stall   = rst_n & bus.start & busy_q & known;
    assign bus.mf_data = !rst_n ? '0 : ((bus.funct == F_MFHI) ? hi_q : lo_q);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
`ifdef MDU_DIV_EN
    localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    int   seen;

    always #5 clk = ~clk;

    mdu_ctrl_if #(.WIDTH(32)) bus ();

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct  = f;
        bus.rs_val = a;
        bus.rt_val = b;
        tick();
        bus.start  = 1'b0;
    endtask

    // Called in cycle 1; returns in the done cycle (or after the bound expires).
    task automatic wait_done(input string tag);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk(tag, 64'(cyc), 64'd35);
    endtask

    task automatic run_seq(input string tag, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        issue(f, a, b);
        chk({tag, "_busy1"}, 64'(bus.busy), 64'd1);
        wait_done({tag, "_done_cycle"});
        chk({tag, "_busy0"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.funct  = 6'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        bus.abort  = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();

        // Reset state
        bus.start = 1'b1;
        bus.funct = F_MFHI;
        #1;
        chk("rst_busy",    64'(bus.busy),    64'd0);
        chk("rst_done",    64'(bus.done),    64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        chk("rst_hi",      64'(bus.hi),      64'd0);
        chk("rst_lo",      64'(bus.lo),      64'd0);
        chk("rst_stall",   64'(bus.stall),   64'd0);
        chk("rst_mf_data", 64'(bus.mf_data), 64'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick();

        // Signed vs unsigned multiply of the same operands
        run_seq("mult_m1x2",  F_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_seq("multu_m1x2", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);

        // Stall while an mflo waits behind mult 3x5
        issue(F_MULT, 32'd3, 32'd5);
        bus.start = 1'b1;
        bus.funct = F_MFLO;
        seen = 0;
        for (int c = 1; c <= 34; c++) begin
            #1;
            if (bus.stall !== 1'b1) seen++;
            tick();
        end
        chk("stall_cycles_1_34_low_count", 64'(seen), 64'd0);
        #1;
        chk("stall_c35",   64'(bus.stall),   64'd0);
        chk("done_c35",    64'(bus.done),    64'd1);
        chk("mf_data_c35", 64'(bus.mf_data), 64'h0000_000F);
        tick();
        bus.start = 1'b0;
        chk("mflo_no_busy", 64'(bus.busy), 64'd0);
        chk("mflo_lo_kept", 64'(bus.lo), 64'h0000_000F);

        // mthi in the done cycle overwrites the freshly written HI
        run_seq("mult_2x3", F_MULT, 32'd2, 32'd3, 32'd0, 32'd6);
        issue(F_MTHI, 32'h0000_00AB, 32'd0);
        chk("mthi_b2b_hi", 64'(bus.hi), 64'h0000_00AB);
        chk("mthi_b2b_lo", 64'(bus.lo), 64'd6);
        chk("mthi_b2b_busy", 64'(bus.busy), 64'd0);

        // Abort in cycle 10 leaves HI/LO untouched and never pulses done
        issue(F_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi_hi", 64'(bus.hi), 64'h0000_1234);
        issue(F_MULT, 32'd3, 32'd5);
        repeat (9) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy_c11", 64'(bus.busy), 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) seen++;
            tick();
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'h0000_1234);
        chk("abort_lo", 64'(bus.lo), 64'd6);

        // Unsupported funct
        issue(6'b111111, 32'hDEAD_BEEF, 32'd1);
        chk("ill_pulse", 64'(bus.illegal), 64'd1);
        chk("ill_busy",  64'(bus.busy),    64'd0);
        tick();
        chk("ill_clear", 64'(bus.illegal), 64'd0);
        chk("ill_hi",    64'(bus.hi),      64'h0000_1234);
        chk("ill_lo",    64'(bus.lo),      64'd6);

`ifdef MDU_DIV_EN
        run_seq("div_m7_2",  F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_seq("divu_7_0",  F_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        run_seq("div_ovf",   F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_seq("div_m7_0",  F_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
`else
        issue(F_DIV, 32'd7, 32'd2);
        chk("nodiv_ill",  64'(bus.illegal), 64'd1);
        chk("nodiv_busy", 64'(bus.busy),    64'd0);
        tick();
        chk("nodiv_ill_clear", 64'(bus.illegal), 64'd0);
        chk("nodiv_busy2",     64'(bus.busy),    64'd0);
        chk("nodiv_hi",        64'(bus.hi),      64'h0000_1234);
        chk("nodiv_lo",        64'(bus.lo),      64'd6);
`endif

        // Reset mid-multiply, then a clean multiply
        issue(F_MULT, 32'd7, 32'd9);
        repeat (5) tick();
        bus.start = 1'b1;
        bus.funct = F_MFHI;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy",    64'(bus.busy),    64'd0);
        chk("mrst_done",    64'(bus.done),    64'd0);
        chk("mrst_illegal", 64'(bus.illegal), 64'd0);
        chk("mrst_hi",      64'(bus.hi),      64'd0);
        chk("mrst_lo",      64'(bus.lo),      64'd0);
        chk("mrst_stall",   64'(bus.stall),   64'd0);
        chk("mrst_mf_data", 64'(bus.mf_data), 64'd0);
        tick();
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick();
        run_seq("mult_2x2", F_MULT, 32'd2, 32'd2, 32'd0, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Parametrised multiply/divide unit for the execute stage. It decodes the R-type `funct` field for the HI/LO operation group and runs iterative multiply and divide sequences over `WIDTH` cycles. It owns the HI/LO registers and raises a stall to the pipeline while a result is pending. It sits beside the ALU decoder and shifter and adds the multi-cycle HI/LO path they lack.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: instruction in EX belongs to the MDU group (op = SPECIAL); `funct` is valid.
- `funct` in 6: R-type function field.
- `rs_val` in WIDTH: operand A (dividend / multiplicand / mthi/mtlo source).
- `rt_val` in WIDTH: operand B (divisor / multiplier).
- `abort` in 1: synchronous flush of the in-flight operation.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `stall` out 1: combinational; hold the pipeline.
- `illegal` out 1: one-cycle pulse, registered; unsupported `funct` issued.
- `hi`, `lo` out WIDTH: architectural HI/LO registers.
- `mf_data` out WIDTH: combinational; `hi` when `funct`=mfhi, otherwise `lo`.

## Operation
- Decoded `funct` values:
  - 011000 mult, 011001 multu
  - 011010 div, 011011 divu
  - 010000 mfhi, 010010 mflo
  - 010001 mthi, 010011 mtlo
- Accept rule: an operation is accepted on a rising edge where `start`=1 and `busy`=0.
- mthi/mtlo: `hi`/`lo` ← `rs_val` at the accept edge; no busy.
- mfhi/mflo: no state change; the pipeline reads `mf_data`.
- States and transitions:
  - IDLE: accepted mult/multu/div/divu → SETUP.
  - SETUP: latch operands. Signed ops take absolute values and record result signs. Clear the iteration counter.
  - ITER: one shift-add (mul) or restoring-subtract (div) step per cycle, for `WIDTH` cycles, then → FIX.
  - FIX: apply signs, write `hi`/`lo`, → IDLE.
- Multiply result: 2·WIDTH-bit product; `hi` = upper half, `lo` = lower half. Signed ops use two's complement.
- Divide result: `lo` = quotient, `hi` = remainder.
  - Quotient sign = sign(rs) XOR sign(rt).
  - Remainder sign = sign(rs).
- Divide by zero: `lo` = all ones, `hi` = `rs_val`. This holds for both signed and unsigned divide.
- Signed overflow (MIN / −1): `lo` = MIN, `hi` = 0. The normal datapath produces this result with no special case.
- `stall` = `start` & `busy` & (`funct` is any of the eight decoded codes).
- Any other `funct` with `start`=1 and `busy`=0 pulses `illegal` next cycle. HI/LO are unchanged.
- `abort`:
  - Takes priority over issue and iteration.
  - From any non-IDLE state, the next state is IDLE with `busy`=0.
  - `hi`/`lo` keep their pre-operation values and `done` does not pulse.
  - `abort` in IDLE has no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `illegal`=0, `hi`=0, `lo`=0, state IDLE.
- With `rst_n` low: `stall`=0 and `mf_data`=0.
- `rst_n` low mid-operation immediately discards the operation.
- Accept edge E0 defines the cycle numbering:
  - Cycle 1 is SETUP; cycles 2..WIDTH+1 are ITER; cycle WIDTH+2 is FIX.
  - `busy`=1 in cycles 1..WIDTH+2.
- At the edge ending FIX, `hi`/`lo` update. In cycle WIDTH+3, `done`=1 and `busy`=0; with WIDTH=32 that is cycle 35.
- Back-to-back: a new mult/div, mthi/mtlo or mfhi/mflo is accepted in the `done` cycle. mfhi/mflo in that cycle return the new value.
- mthi/mtlo in the `done` cycle overwrite the just-written register at the next edge.
- `start` while `busy` is never accepted, and `stall` holds for that request.

## Configuration
- `MDU_DIV_EN` defined: div/divu are supported as above.
- `MDU_DIV_EN` undefined:
  - The divider datapath and its sign logic are removed.
  - div/divu are treated as unsupported and pulse `illegal`.
  - Multiply timing is unchanged.

## Test plan
- mult with rs=0xFFFFFFFF, rt=2 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. multu with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE. In both cases `done` is asserted in cycle 35 after the accept edge.
- div −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu 7/0 → `lo`=0xFFFFFFFF, `hi`=0x00000007. div 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Issue mult 3×5, then hold `start` with mflo → `stall`=1 for cycles 1..34. In cycle 35, `stall`=0 and `mf_data`=0x0000000F.
- Set `hi`=0x1234 via mthi, issue mult, assert `abort` in cycle 10 → `busy`=0 from cycle 11, no `done`, `hi` stays 0x1234.
- Drop `rst_n` mid-multiply → all outputs 0 immediately. After release, mult 2×2 completes normally.
- funct 111111 with `start` → `illegal` pulses for one cycle. With `MDU_DIV_EN` undefined, div → `illegal` pulse, `busy` stays 0.
